param_seq_detector: RTL
=======================

Name: param_seq_detector

Overview:
- Parametrised serial bit-sequence detector. Supersedes the fixed-pattern Moore/Mealy detectors.
- Adds configurable pattern length, a runtime-loadable pattern, overlap/non-overlap matching and compile-time Moore/Mealy output selection.
- Adds an input-valid qualifier and a saturating match counter.
- Sits on a serial bit stream in the control path; z feeds downstream event logic and match_count is software-visible status.

Parameters:
- PATTERN_W, 4, pattern length in bits; legal range 2..16.
- PATTERN, 4'b1101, reset value of the pattern register; MSB is the first bit received.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = history discarded after each match.
- MOORE, 0, 0 = Mealy output (combinational, same cycle); 1 = Moore output (registered, next cycle).
- CNT_W, 8, width of match_count.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- en  input  1  x valid this cycle; when low, x is ignored and all history is held
- x  input  1  serial data bit
- cfg_we  input  1  load cfg_pattern into the pattern register
- cfg_pattern  input  PATTERN_W  new pattern; MSB is the first bit received
- cnt_clr  input  1  synchronous clear of match_count
- z  output  1  match pulse
- match_count  output  CNT_W  saturating number of matches
- busy_fill  output  log2(PATTERN_W)+1  number of valid history bits, 0..PATTERN_W-1

Behaviour:
- Reset (rst=1 at a clk edge): pattern register <= PATTERN; hist <= 0; fill <= 0; Moore z register <= 0; match_count <= 0.
- While rst is asserted, Mealy z is forced to 0.
- State:
  - hist: PATTERN_W-1 bits, the most recent accepted bits, newest in the LSB.
  - fill: count of valid history bits, saturating at PATTERN_W-1.
- Hit equation: hit = en & ~cfg_we & (fill == PATTERN_W-1) & ({hist, x} == pattern).
- Accepted bit (en=1, cfg_we=0):
  - hist <= {hist[PATTERN_W-3:0], x}.
  - fill <= min(fill+1, PATTERN_W-1).
  - If hit and OVERLAP=0: fill <= 0 instead; hist contents become don't-care.
- en=0: hist, fill and pattern held; hit = 0.
- Output timing:
  - MOORE=0: z = hit, combinational, asserted in the same cycle as the final pattern bit.
  - MOORE=1: z register <= hit every clock, so z is a one-cycle pulse the cycle after the final bit.
  - MOORE=1 and en=0: z register <= 0.
- Back-to-back matches (OVERLAP=1, periodic pattern): z may be high on consecutive cycles; no minimum gap.
- cfg_we=1:
  - pattern <= cfg_pattern; fill <= 0; Moore z register <= 0.
  - x is ignored that cycle, even when en=1.
  - The new pattern applies from the next accepted bit.
- match_count:
  - Increments by 1 on each clock where hit=1.
  - Saturates at 2^CNT_W-1, with no wrap.
  - cnt_clr=1 clears it to 0; a hit in the same cycle is not counted.
- Priority: rst > cfg_we > normal shift; cnt_clr is independent of the shift path and acts only on match_count.
- Reset mid-sequence discards all partial history; the first PATTERN_W-1 accepted bits after reset can never produce a hit.
- busy_fill = fill, registered.

Test Plan:
1. Defaults (1101, OVERLAP=1, MOORE=0), en=1, x = 1,1,0,1,1,0,1 -> z high on bits 4 and 7 (same cycle as each bit); match_count=2.
2. Same stream, OVERLAP=0 -> z high on bit 4 only; busy_fill=0 after bit 4 and 3 after bit 7; match_count=1.
3. MOORE=1, stream from scenario 1 -> z high in the cycle after bits 4 and 7, exactly one cycle wide each.
4. Gaps and mid-sequence reset:
   - x=1,1,0 with en=1, then en=0 for 3 cycles with x=1, then x=1 with en=1 -> single hit.
   - Repeat with a rst pulse inserted during the gap -> no hit; busy_fill=1 after the final bit.
5. cfg_we with cfg_pattern=4'b0110 while fill=2 -> busy_fill=0 next cycle; subsequent x = 0,1,1,0,1,1,0 -> hits on bits 4 and 7.
6. CNT_W=2, stream 1101 repeated 5 times with OVERLAP=0 -> match_count saturates at 3. Then cnt_clr asserted on the cycle of a hit -> match_count=0, and that hit is not counted.

Source files
------------

// File: rtl/param_seq_detector.sv
// Serial bit-sequence detector with a runtime-loadable pattern, overlap control,
// Mealy or Moore match output and a saturating match counter.
module param_seq_detector #(
   parameter int unsigned              PATTERN_W = 4,
   parameter logic [PATTERN_W-1:0]     PATTERN   = 4'b1101,
   parameter bit                       OVERLAP   = 1'b1,
   parameter bit                       MOORE     = 1'b0,
   parameter int unsigned              CNT_W     = 8,
   localparam int unsigned             FILL_W    = $clog2(PATTERN_W) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 x,
   input  logic                 cfg_we,
   input  logic [PATTERN_W-1:0] cfg_pattern,
   input  logic                 cnt_clr,
   output logic                 z,
   output logic [CNT_W-1:0]     match_count,
   output logic [FILL_W-1:0]    busy_fill
);

   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PATTERN_W - 1);

   logic [PATTERN_W-1:0] pattern_q;
   logic [PATTERN_W-2:0] hist_q;
   logic [FILL_W-1:0]    fill_q;
   logic [CNT_W-1:0]     count_q;
   logic [PATTERN_W-1:0] window;
   logic                 accept;
   logic                 hit;

   assign window = {hist_q, x};
   assign accept = en & ~cfg_we;
   assign hit    = accept & (fill_q == FILL_MAX) & (window == pattern_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         pattern_q <= PATTERN;
         hist_q    <= '0;
         fill_q    <= '0;
      end else if (cfg_we) begin
         pattern_q <= cfg_pattern;
         fill_q    <= '0;
      end else if (en) begin
         hist_q <= window[PATTERN_W-2:0];
         // Non-overlapping mode restarts the fill so old bits cannot join a new match
         if (hit && !OVERLAP)
            fill_q <= '0;
         else if (fill_q != FILL_MAX)
            fill_q <= fill_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || cnt_clr)
         count_q <= '0;
      else if (hit && (count_q != '1))
         count_q <= count_q + 1'b1;
   end

   generate
      if (MOORE) begin : g_moore
         logic z_q;
         // hit is already low when en=0 or cfg_we=1, so the register clears in those cycles
         always_ff @(posedge clk) begin
            if (rst)
               z_q <= 1'b0;
            else
               z_q <= hit;
         end
         assign z = z_q;
      end else begin : g_mealy
         assign z = hit & ~rst;
      end
   endgenerate

   assign match_count = count_q;
   assign busy_fill   = fill_q;

endmodule
